// File: rtl/mem_stage_wb_pkg.sv
// Shared definitions for the MEM stage: write-back control bit positions,
// access FSM state encoding and the hard-wired zero register number.
package mem_stage_wb_pkg;

   localparam int WB_REGWRITE = 3;
   localparam int WB_MEMTOREG = 2;
   localparam int WB_PCTOREG  = 1;
   localparam int WB_HALT     = 0;

   localparam logic [3:0] REG_ZERO = 4'd0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } acc_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: issues the req/ready handshake, holds the
// request (address, data, direction, WB payload) stable while the memory
// is busy, counts wait cycles for the optional timeout and raises stall.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   access            a memory operation is present this cycle (already
//                     masked by halt)
//   wr_in             1 = store (store wins over load)
//   addr_in/wdata_in  live address / store data (already forwarded)
//   ctrl_in/dst_in/flags_in  live WB payload of the MEM-stage instruction
//   mem_ready         memory completion strobe
//   mem_req/mem_wr/mem_addr/mem_wdata  memory request bus
//   stall             freeze upstream stages
//   issue             IDLE cycle that starts an access
//   complete          access finishes this cycle (ready or timeout)
//   timeout_hit       completion forced by the wait limit
//   cur_ctrl/cur_dst/cur_flags  WB payload of the access in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access outstanding; a new access may issue and complete
// ST_WAIT | access issued, memory not ready yet; request held from regs
module mem_access_fsm #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              access,
   input  logic              wr_in,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic [3:0]        ctrl_in,
   input  logic [3:0]        dst_in,
   input  logic [2:0]        flags_in,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              stall,
   output logic              issue,
   output logic              complete,
   output logic              timeout_hit,
   output logic [3:0]        cur_ctrl,
   output logic [3:0]        cur_dst,
   output logic [2:0]        cur_flags
);
   import mem_stage_wb_pkg::*;

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   acc_state_e        state, state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic              hold_wr;
   logic [DATA_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;
   logic [3:0]        hold_ctrl;
   logic [3:0]        hold_dst;
   logic [2:0]        hold_flags;

   logic              req_c;
   logic              stall_c;
   logic              wr_c;
   logic [DATA_W-1:0] addr_c;
   logic [DATA_W-1:0] wdata_c;

   always_comb begin
      state_nxt   = state;
      req_c       = 1'b0;
      stall_c     = 1'b0;
      issue       = 1'b0;
      complete    = 1'b0;
      timeout_hit = 1'b0;
      wr_c        = wr_in;
      addr_c      = addr_in;
      wdata_c     = wdata_in;
      cur_ctrl    = ctrl_in;
      cur_dst     = dst_in;
      cur_flags   = flags_in;
      case (state)
         ST_IDLE: begin
            if (access) begin
               req_c = 1'b1;
               issue = 1'b1;
               if (mem_ready) begin
                  complete = 1'b1;
               end else begin
                  stall_c   = 1'b1;
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            req_c     = 1'b1;
            wr_c      = hold_wr;
            addr_c    = hold_addr;
            wdata_c   = hold_wdata;
            cur_ctrl  = hold_ctrl;
            cur_dst   = hold_dst;
            cur_flags = hold_flags;
            if (mem_ready) begin
               complete  = 1'b1;
               state_nxt = ST_IDLE;
            end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LIMIT)) begin
               complete    = 1'b1;
               timeout_hit = 1'b1;
               state_nxt   = ST_IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request and stall are also qualified by reset so an in-flight access
   // is dropped the moment reset asserts, not at the next edge.
   assign mem_req   = rst & req_c;
   assign mem_wr    = rst & req_c & wr_c;
   assign stall     = rst & stall_c;
   assign mem_addr  = addr_c;
   assign mem_wdata = wdata_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         hold_wr    <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_ctrl  <= '0;
         hold_dst   <= '0;
         hold_flags <= '0;
      end else begin
         state <= state_nxt;
         if (issue) begin
            wait_cnt   <= '0;
            hold_wr    <= wr_in;
            hold_addr  <= addr_in;
            hold_wdata <= wdata_in;
            hold_ctrl  <= ctrl_in;
            hold_dst   <= dst_in;
            hold_flags <= flags_in;
         end else if ((state == ST_WAIT) && !complete) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_stage_wb.sv
// MEM pipeline stage: consumes EX/MEM outputs, runs the data-memory access
// through mem_access_fsm, forwards a just-loaded value to a dependent store
// and holds the MEM/WB register plus the sticky halt flag.
//
// Ports:
//   clk, rst                   clock, async active-low reset
//   MemWrite, MemRead          memory operation of the MEM-stage instruction
//   to_WBReg                   {RegWrite, MemtoReg, PCtoReg, Halt}
//   flagsIn, reg_data_in       ALU flags, ALU result / memory address
//   rt_in, DstReg_in, SrcReg1_in  store data, destination, store-data source
//   mem_*                      data-memory request/response bus
//   stall                      freeze upstream while an access is pending
//   wb_ctrl, wb_data, wb_DstReg, flagsOut  MEM/WB register
//   halted                     sticky halt indicator
//   mem_err                    pulse on read/write conflict or timeout
module mem_stage_wb #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [3:0]        to_WBReg,
   input  logic [2:0]        flagsIn,
   input  logic [DATA_W-1:0] reg_data_in,
   input  logic [DATA_W-1:0] rt_in,
   input  logic [3:0]        DstReg_in,
   input  logic [3:0]        SrcReg1_in,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall,
   output logic [3:0]        wb_ctrl,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        wb_DstReg,
   output logic [2:0]        flagsOut,
   output logic              halted,
   output logic              mem_err
);
   import mem_stage_wb_pkg::*;

   logic              any_mem;
   logic              access;
   logic              fwd;
   logic [DATA_W-1:0] store_data;
   logic              issue;
   logic              complete;
   logic              timeout_hit;
   logic [3:0]        cur_ctrl;
   logic [3:0]        cur_dst;
   logic [2:0]        cur_flags;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] cplt_data;

   assign any_mem = MemRead | MemWrite;
   assign access  = any_mem & ~halted;

   // Load in WB feeding the store data of the store now in MEM.
   assign fwd = MemWrite & wb_ctrl[WB_REGWRITE] & wb_ctrl[WB_MEMTOREG] &
                (wb_DstReg == SrcReg1_in) & (SrcReg1_in != REG_ZERO);
   assign store_data = fwd ? wb_data : rt_in;

   mem_access_fsm #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .access      (access),
      .wr_in       (MemWrite),
      .addr_in     (reg_data_in),
      .wdata_in    (store_data),
      .ctrl_in     (to_WBReg),
      .dst_in      (DstReg_in),
      .flags_in    (flagsIn),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .stall       (stall),
      .issue       (issue),
      .complete    (complete),
      .timeout_hit (timeout_hit),
      .cur_ctrl    (cur_ctrl),
      .cur_dst     (cur_dst),
      .cur_flags   (cur_flags)
   );

   assign rd_data   = timeout_hit ? '0 : mem_rdata;
   assign cplt_data = mem_wr ? mem_addr : rd_data;
   assign mem_err   = rst & ((issue & MemRead & MemWrite) | timeout_hit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_ctrl   <= '0;
         wb_data   <= '0;
         wb_DstReg <= '0;
         flagsOut  <= '0;
         halted    <= 1'b0;
      end else if (complete) begin
         wb_ctrl   <= cur_ctrl;
         wb_data   <= cplt_data;
         wb_DstReg <= cur_dst;
         flagsOut  <= cur_flags;
         if (cur_ctrl[WB_HALT]) halted <= 1'b1;
      end else if (mem_req || any_mem) begin
         // Access still pending, or suppressed after halt: insert a bubble.
         wb_ctrl <= '0;
      end else begin
         wb_ctrl   <= to_WBReg;
         wb_data   <= reg_data_in;
         wb_DstReg <= DstReg_in;
         flagsOut  <= flagsIn;
         if (to_WBReg[WB_HALT]) halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage_wb.sv
module tb_mem_stage_wb;

   localparam int DW = 16;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          MemWrite, MemRead;
   logic [3:0]    to_WBReg;
   logic [2:0]    flagsIn;
   logic [DW-1:0] reg_data_in, rt_in;
   logic [3:0]    DstReg_in, SrcReg1_in;
   logic          mem_req, mem_wr;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic          mem_ready;
   logic          stall;
   logic [3:0]    wb_ctrl;
   logic [DW-1:0] wb_data;
   logic [3:0]    wb_DstReg;
   logic [2:0]    flagsOut;
   logic          halted, mem_err;

   always #5 clk = ~clk;

   mem_stage_wb #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .MemWrite(MemWrite), .MemRead(MemRead), .to_WBReg(to_WBReg),
      .flagsIn(flagsIn), .reg_data_in(reg_data_in), .rt_in(rt_in),
      .DstReg_in(DstReg_in), .SrcReg1_in(SrcReg1_in),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall(stall), .wb_ctrl(wb_ctrl), .wb_data(wb_data),
      .wb_DstReg(wb_DstReg), .flagsOut(flagsOut), .halted(halted),
      .mem_err(mem_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      MemWrite = 0; MemRead = 0; to_WBReg = 0; flagsIn = 0;
      reg_data_in = 0; rt_in = 0; DstReg_in = 0; SrcReg1_in = 0;
      mem_rdata = 0; mem_ready = 0;
   endtask

   typedef struct {
      logic          rd;
      logic          wr;
      logic [3:0]    ctrl;
      logic [3:0]    dst;
      logic [2:0]    flg;
      logic [15:0]   addr;
      logic [15:0]   rt;
      logic [3:0]    src;
      logic [15:0]   rdata;
      logic          e_req;
      logic          e_wr;
      logic [15:0]   e_wdata;
      logic          e_err;
      logic [3:0]    e_ctrl;
      logic [15:0]   e_data;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //           rd wr ctrl  dst  flg  addr      rt        src  rdata     req wr wdata     err ctrl  data
      vecs[0]  = '{0, 0, 4'h8, 4'd2, 3'd5, 16'h0007, 16'h0000, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 4'h8, 16'h0007};
      vecs[1]  = '{1, 0, 4'hC, 4'd5, 3'd1, 16'h0040, 16'h0000, 4'd0, 16'hBEEF, 1, 0, 16'h0000, 0, 4'hC, 16'hBEEF};
      vecs[2]  = '{1, 0, 4'hC, 4'd3, 3'd2, 16'h0050, 16'h0000, 4'd0, 16'h00AA, 1, 0, 16'h0000, 0, 4'hC, 16'h00AA};
      vecs[3]  = '{0, 1, 4'h0, 4'd0, 3'd0, 16'h0060, 16'h5555, 4'd3, 16'h0000, 1, 1, 16'h00AA, 0, 4'h0, 16'h0060};
      vecs[4]  = '{1, 0, 4'hC, 4'd0, 3'd0, 16'h0070, 16'h0000, 4'd0, 16'h00AA, 1, 0, 16'h0000, 0, 4'hC, 16'h00AA};
      vecs[5]  = '{0, 1, 4'h0, 4'd0, 3'd0, 16'h0080, 16'h5555, 4'd0, 16'h0000, 1, 1, 16'h5555, 0, 4'h0, 16'h0080};
      vecs[6]  = '{1, 0, 4'hC, 4'd3, 3'd4, 16'h0090, 16'h0000, 4'd0, 16'h1111, 1, 0, 16'h0000, 0, 4'hC, 16'h1111};
      vecs[7]  = '{0, 1, 4'h0, 4'd0, 3'd0, 16'h00A0, 16'h2222, 4'd4, 16'h0000, 1, 1, 16'h2222, 0, 4'h0, 16'h00A0};
      vecs[8]  = '{0, 0, 4'h8, 4'd6, 3'd6, 16'h0033, 16'h0000, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 4'h8, 16'h0033};
      vecs[9]  = '{0, 1, 4'h0, 4'd0, 3'd0, 16'h00B0, 16'h4444, 4'd6, 16'h0000, 1, 1, 16'h4444, 0, 4'h0, 16'h00B0};
      vecs[10] = '{1, 1, 4'h0, 4'd0, 3'd0, 16'h00C0, 16'h7777, 4'd0, 16'h9999, 1, 1, 16'h7777, 1, 4'h0, 16'h00C0};
      vecs[11] = '{0, 0, 4'hA, 4'd7, 3'd2, 16'h1234, 16'h0000, 4'd0, 16'h0000, 0, 0, 16'h0000, 0, 4'hA, 16'h1234};

      // reset state
      rst = 0;
      idle_inputs();
      #12;
      chk("rst_req",   32'(mem_req), 0);
      chk("rst_wr",    32'(mem_wr), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_err",   32'(mem_err), 0);
      chk("rst_halt",  32'(halted), 0);
      chk("rst_ctrl",  32'(wb_ctrl), 0);
      chk("rst_data",  32'(wb_data), 0);
      chk("rst_dst",   32'(wb_DstReg), 0);
      chk("rst_flags", 32'(flagsOut), 0);
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1;

      // single-cycle vectors
      for (int i = 0; i < NV; i++) begin
         MemRead = vecs[i].rd; MemWrite = vecs[i].wr; to_WBReg = vecs[i].ctrl;
         DstReg_in = vecs[i].dst; flagsIn = vecs[i].flg; reg_data_in = vecs[i].addr;
         rt_in = vecs[i].rt; SrcReg1_in = vecs[i].src; mem_rdata = vecs[i].rdata;
         mem_ready = 1;
         @(negedge clk);
         chk($sformatf("v%0d_req", i),   32'(mem_req), 32'(vecs[i].e_req));
         chk($sformatf("v%0d_stall", i), 32'(stall), 0);
         chk($sformatf("v%0d_err", i),   32'(mem_err), 32'(vecs[i].e_err));
         if (vecs[i].e_req) begin
            chk($sformatf("v%0d_wr", i),   32'(mem_wr), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            if (vecs[i].e_wr)
               chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
         end
         @(posedge clk); #1;
         chk($sformatf("v%0d_wbctrl", i), 32'(wb_ctrl), 32'(vecs[i].e_ctrl));
         chk($sformatf("v%0d_wbdata", i), 32'(wb_data), 32'(vecs[i].e_data));
         chk($sformatf("v%0d_wbdst", i),  32'(wb_DstReg), 32'(vecs[i].dst));
         chk($sformatf("v%0d_flags", i),  32'(flagsOut), 32'(vecs[i].flg));
      end

      // 3-wait store, live inputs scrambled while waiting
      idle_inputs();
      MemWrite = 1; reg_data_in = 16'h0010; rt_in = 16'h1234; to_WBReg = 4'b0010;
      DstReg_in = 4'd9; flagsIn = 3'b110;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         @(negedge clk);
         chk($sformatf("w3_req%0d", i),   32'(mem_req), 1);
         chk($sformatf("w3_wr%0d", i),    32'(mem_wr), 1);
         chk($sformatf("w3_addr%0d", i),  32'(mem_addr), 'h0010);
         chk($sformatf("w3_wdata%0d", i), 32'(mem_wdata), 'h1234);
         chk($sformatf("w3_stall%0d", i), 32'(stall), (i < 3) ? 1 : 0);
         @(posedge clk); #1;
         if (i < 3) chk($sformatf("w3_bubble%0d", i), 32'(wb_ctrl), 0);
         if (i == 0) begin
            reg_data_in = 16'hFFFF; rt_in = 16'hFFFF; DstReg_in = 4'hF;
            flagsIn = 3'b000; to_WBReg = 4'hF;
         end
      end
      chk("w3_ctrl",  32'(wb_ctrl), 'b0010);
      chk("w3_data",  32'(wb_data), 'h0010);
      chk("w3_dst",   32'(wb_DstReg), 9);
      chk("w3_flags", 32'(flagsOut), 'b110);
      chk("w3_halt",  32'(halted), 0);

      // forwarded store data survives a stall
      idle_inputs();
      MemRead = 1; reg_data_in = 16'h0050; to_WBReg = 4'b1100; DstReg_in = 4'd3;
      mem_rdata = 16'h00AA; mem_ready = 1;
      @(posedge clk); #1;
      chk("fs_load", 32'(wb_data), 'h00AA);
      idle_inputs();
      MemWrite = 1; SrcReg1_in = 4'd3; rt_in = 16'h5555; reg_data_in = 16'h0064;
      @(negedge clk);
      chk("fs_wdata_issue", 32'(mem_wdata), 'h00AA);
      chk("fs_stall_issue", 32'(stall), 1);
      @(posedge clk); #1;
      chk("fs_bubble", 32'(wb_ctrl), 0);
      mem_ready = 1;
      @(negedge clk);
      chk("fs_wdata_wait", 32'(mem_wdata), 'h00AA);
      chk("fs_stall_done", 32'(stall), 0);
      @(posedge clk); #1;
      chk("fs_wbdata", 32'(wb_data), 'h0064);

      // timeout: 4 WAIT cycles then forced completion
      idle_inputs();
      MemRead = 1; reg_data_in = 16'h0020; to_WBReg = 4'b1100; DstReg_in = 4'd8;
      flagsIn = 3'b011; mem_rdata = 16'hDEAD;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("to_req%0d", i),   32'(mem_req), 1);
         chk($sformatf("to_stall%0d", i), 32'(stall), (i < 5) ? 1 : 0);
         chk($sformatf("to_err%0d", i),   32'(mem_err), (i == 5) ? 1 : 0);
         @(posedge clk); #1;
         if (i < 5) chk($sformatf("to_bubble%0d", i), 32'(wb_ctrl), 0);
      end
      chk("to_data",  32'(wb_data), 0);
      chk("to_ctrl",  32'(wb_ctrl), 'b1100);
      chk("to_dst",   32'(wb_DstReg), 8);
      chk("to_flags", 32'(flagsOut), 'b011);

      // reset during the second WAIT cycle
      MemRead = 1; reg_data_in = 16'h0030; to_WBReg = 4'b1100; DstReg_in = 4'd1;
      flagsIn = 3'b111; mem_ready = 0;
      @(negedge clk);
      chk("rw_err_after_to", 32'(mem_err), 0);
      chk("rw_stall_issue",  32'(stall), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw_stall_w1", 32'(stall), 1);
      @(posedge clk); #2;
      rst = 0;
      #1;
      chk("rw_req",   32'(mem_req), 0);
      chk("rw_stall", 32'(stall), 0);
      chk("rw_wr",    32'(mem_wr), 0);
      chk("rw_err",   32'(mem_err), 0);
      chk("rw_ctrl",  32'(wb_ctrl), 0);
      chk("rw_data",  32'(wb_data), 0);
      chk("rw_dst",   32'(wb_DstReg), 0);
      chk("rw_flags", 32'(flagsOut), 0);
      chk("rw_halt",  32'(halted), 0);
      idle_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1;

      // halt is sticky and suppresses later accesses
      to_WBReg = 4'b0001;
      @(posedge clk); #1;
      chk("h_set",  32'(halted), 1);
      chk("h_ctrl", 32'(wb_ctrl), 'b0001);
      idle_inputs();
      MemRead = 1; reg_data_in = 16'h0044; to_WBReg = 4'b1100; DstReg_in = 4'd2;
      mem_rdata = 16'h1357; mem_ready = 1;
      @(negedge clk);
      chk("h_rd_req",   32'(mem_req), 0);
      chk("h_rd_stall", 32'(stall), 0);
      @(posedge clk); #1;
      chk("h_rd_bubble", 32'(wb_ctrl), 0);
      chk("h_sticky1",   32'(halted), 1);
      MemRead = 0; MemWrite = 1;
      @(negedge clk);
      chk("h_wr_req", 32'(mem_req), 0);
      @(posedge clk); #1;
      chk("h_sticky2", 32'(halted), 1);
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_wb.md
Name: mem_stage_wb

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs; the read side of that interface.
- Drives the multi-cycle data memory via a req/ready handshake and stalls upstream while an access is outstanding.
- Performs Mem2Mem store-data forwarding and holds the MEM/WB pipeline register that feeds write-back.

Parameters:
- DATA_W, 16, data/address width.
- TIMEOUT, 0, maximum WAIT cycles before forced completion; 0 means no limit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store in MEM stage, from EX/MEM.
- MemRead  in  1  load in MEM stage, from EX/MEM.
- to_WBReg  in  4  WB controls: [3] RegWrite, [2] MemtoReg, [1] PCtoReg, [0] Halt.
- flagsIn  in  3  ALU flags from EX/MEM.
- reg_data_in  in  DATA_W  ALU result / memory address.
- rt_in  in  DATA_W  store data.
- DstReg_in  in  4  destination register.
- SrcReg1_in  in  4  store-data source register, used for Mem2Mem forwarding.
- mem_req  out  1  memory request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  request address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid while mem_ready=1.
- mem_ready  in  1  access complete.
- stall  out  1  freezes IF/ID/EX and EX/MEM.
- wb_ctrl  out  4  registered WB controls (same bit order as to_WBReg).
- wb_data  out  DATA_W  registered write-back value.
- wb_DstReg  out  4  registered destination register.
- flagsOut  out  3  registered flags.
- halted  out  1  sticky halt indicator.
- mem_err  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - mem_req, mem_wr, stall, mem_err, halted, wb_ctrl, wb_data, wb_DstReg, flagsOut all 0.
  - Aborts any in-flight access immediately; mem_req drops without waiting for a clock edge.
- Access present when MemRead|MemWrite=1 and halted=0.
- Conflicting MemRead=1 and MemWrite=1:
  - Write wins.
  - mem_err pulses 1 cycle in the issue cycle.
- Mem2Mem forwarding (fwd):
  - Condition: MemWrite=1, wb_ctrl[3]=1, wb_ctrl[2]=1, wb_DstReg==SrcReg1_in, SrcReg1_in!=0.
  - When fwd, store data = wb_data; otherwise store data = rt_in.
- FSM states: IDLE, WAIT.
- IDLE, no access:
  - mem_req=0, stall=0.
  - MEM/WB latches to_WBReg / reg_data_in / DstReg_in / flagsIn at the edge.
- IDLE, access present:
  - Combinationally drive mem_req=1, mem_wr, mem_addr=reg_data_in, mem_wdata=(forwarded) store data.
  - Capture addr, wdata, wr, to_WBReg, DstReg_in, flagsIn into hold registers.
  - mem_ready=1 same cycle: complete, zero-stall path, stay IDLE.
  - mem_ready=0: stall=1, go to WAIT, wait counter=0.
- WAIT:
  - mem_req=1; address/data/wr driven from hold registers and stable until completion.
  - stall=1 each cycle.
  - MEM/WB loads a bubble (wb_ctrl=0) each WAIT cycle, so WB never repeats an instruction.
  - mem_ready=1: complete; stall=0 that cycle; next state IDLE.
  - With TIMEOUT>0, counter reaching TIMEOUT forces completion with read data 0 and pulses mem_err.
- Completion edge, MEM/WB loads from the hold registers (IDLE path uses live inputs):
  - wb_data = mem_rdata if load, else ALU result.
  - wb_ctrl, wb_DstReg, flagsOut from the held values.
- Halt:
  - When a completing/latched instruction has Halt=1, halted is set at that edge and stays set until reset.
  - Later accesses are suppressed (no mem_req) and treated as bubbles.
- Forwarding during a stall uses the captured wdata, so forwarding is never lost to bubble insertion.
- Latency: MEM/WB updates 1 edge after the issue cycle for a 0-wait memory, N+1 edges for N wait cycles.

Decomposition:
- Shared package:
  - WB bit indices (WB_REGWRITE=3, WB_MEMTOREG=2, WB_PCTOREG=1, WB_HALT=0).
  - FSM state encoding.
  - Register-0 constant.
- One natural sub-module: mem_access_fsm, covering the handshake, hold registers, wait counter and stall generation.
- MEM/WB storage and forwarding stay in the top module.

Test Plan:
- 0-wait load: MemRead=1, addr 0x0040, mem_ready=1, rdata 0xBEEF, to_WBReg=4'b1100, DstReg 5 -> stall never 1; next edge wb_data=0xBEEF, wb_ctrl=4'b1100, wb_DstReg=5.
- 3-wait store: MemWrite=1, addr 0x0010, rt 0x1234, ready after 3 cycles -> stall=1 for 3 cycles; mem_addr/mem_wdata stable; 3 bubbles with wb_ctrl=0; then store completes.
- Mem2Mem: load to R3 (data 0x00AA) then SW with SrcReg1=3, rt_in=0x5555 -> mem_wdata=0x00AA. Repeat with SrcReg1=0 -> mem_wdata=0x5555.
- Conflict: MemRead=MemWrite=1 -> mem_wr=1, mem_err pulses exactly 1 cycle.
- TIMEOUT=4, mem_ready held 0 -> after 4 WAIT cycles forced completion, wb_data=0, mem_err=1 for one cycle, stall drops.
- Reset in WAIT cycle 2 -> mem_req=0 and stall=0 immediately; all outputs 0. After release, Halt instruction -> halted=1 sticky; subsequent MemRead produces no mem_req.
